// File: rtl/ofdm_ltf_inserter.sv
// Inserts NUM_LTF 64-bin 802.11 long training fields ahead of each frame's data
// symbols; data is otherwise forwarded bit-exact through one output register stage.
module ofdm_ltf_inserter #(
  parameter logic signed [15:0] AMPLITUDE = 16'sd16384,
  parameter int unsigned        NUM_LTF   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sof_i,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        o_sof
);

  typedef enum logic {ST_PASS, ST_PREAMBLE} state_t;

  // Sign of the +/-1 bins in natural bin order (MSB = lowest bin), 1 = negative.
  localparam logic [25:0] LO_NEG   = 26'b0011_0010_1000_0001_1001_0100_00;
  localparam logic [25:0] HI_NEG   = 26'b0110_0101_0111_1100_1101_0100_00;
  localparam logic [63:0] LTF_NEG  = {6'b0, LO_NEG, 1'b0, HI_NEG, 5'b0};
  localparam logic [63:0] LTF_NZ   = {6'b0, {26{1'b1}}, 1'b0, {26{1'b1}}, 5'b0};
  localparam logic [15:0] AMP_POS  = AMPLITUDE;
  localparam logic [15:0] AMP_NEG  = 16'(-AMPLITUDE);
  localparam logic [1:0]  LAST_LTF = 2'(NUM_LTF - 1);

  state_t      state_q;
  logic        pending_q;
  logic        in_pkt_q;
  logic        last_sof_q;
  logic [5:0]  bin_q;
  logic [5:0]  bin_d;
  logic [1:0]  ltf_cnt_q;
  logic [1:0]  ltf_cnt_d;
  logic [31:0] tdata_q;
  logic        tlast_q;
  logic        tvalid_q;
  logic        sof_q;

  logic        load;
  logic        sof_edge;
  logic        start_pre;
  logic        accept;
  logic [31:0] ltf_rom [64];

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_ltf
      assign ltf_rom[gi] = !LTF_NZ[63-gi] ? 32'd0 :
                           LTF_NEG[63-gi] ? {AMP_NEG, 16'h0000} : {AMP_POS, 16'h0000};
    end
  endgenerate

  assign load      = ~tvalid_q | o_tready;
  assign sof_edge  = sof_i & ~last_sof_q;
  // A pending preamble only starts on a symbol boundary.
  assign start_pre = (state_q == ST_PASS) & pending_q & ~in_pkt_q;
  assign i_tready  = (state_q == ST_PASS) & load & ~start_pre;
  assign accept    = i_tvalid & i_tready;
  assign bin_d     = bin_q + 6'd1;
  assign ltf_cnt_d = ltf_cnt_q + 2'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_PASS;
      pending_q  <= 1'b0;
      in_pkt_q   <= 1'b0;
      last_sof_q <= 1'b0;
      bin_q      <= 6'd0;
      ltf_cnt_q  <= 2'd0;
      tdata_q    <= 32'd0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      sof_q      <= 1'b0;
    end else begin
      last_sof_q <= sof_i;
      if (accept) in_pkt_q <= ~i_tlast;
      if (load && start_pre) pending_q <= 1'b0;
      // An edge arriving on the very cycle pending clears arms the next frame.
      if (sof_edge && state_q == ST_PASS) pending_q <= 1'b1;

      case (state_q)
        ST_PASS: begin
          if (load) begin
            if (start_pre) begin
              state_q  <= ST_PREAMBLE;
              tvalid_q <= 1'b0;
            end else if (accept) begin
              tdata_q  <= i_tdata;
              tlast_q  <= i_tlast;
              sof_q    <= 1'b0;
              tvalid_q <= 1'b1;
            end else begin
              tvalid_q <= 1'b0;
            end
          end
        end
        ST_PREAMBLE: begin
          if (load) begin
            tdata_q  <= ltf_rom[bin_q];
            tlast_q  <= (bin_q == 6'd63);
            sof_q    <= (bin_q == 6'd0) && (ltf_cnt_q == 2'd0);
            tvalid_q <= 1'b1;
            bin_q    <= bin_d;
            if (bin_q == 6'd63) begin
              if (ltf_cnt_q == LAST_LTF) begin
                ltf_cnt_q <= 2'd0;
                state_q   <= ST_PASS;
              end else begin
                ltf_cnt_q <= ltf_cnt_d;
              end
            end
          end
        end
        default: state_q <= ST_PASS;
      endcase
    end
  end

  assign o_tdata  = tdata_q;
  assign o_tlast  = tlast_q;
  assign o_tvalid = tvalid_q;
  assign o_sof    = sof_q;

endmodule

// File: tb/tb_ofdm_ltf_inserter.sv
// Bench for ofdm_ltf_inserter: a reference model builds the expected output beat list
// from the LTF table and the input symbols; a monitor captures and stall-checks the DUT.
module tb_ofdm_ltf_inserter;

  localparam logic signed [15:0] AMP  = 16'sd16384;
  localparam int                 NLTF = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        sof;
  } beat_t;

  typedef struct {
    int          beat;
    logic [31:0] data;
    logic        last;
    logic        sof;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        sof_i = 1'b0;
  logic [31:0] i_tdata = 32'd0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic        o_sof;

  int n_checks = 0;
  int n_pass = 0;
  int n_acc = 0;
  logic rdy_rand = 1'b0;

  beat_t       cap_q [$];
  beat_t       exp_q [$];
  logic [31:0] din_q [$];
  vec_t        tbl [12];

  int ltf_tab [64] = '{0, 0, 0, 0, 0, 0,
                       1, 1, -1, -1, 1, 1, -1, 1, -1, 1, 1, 1, 1, 1, 1, -1, -1, 1, 1, -1, 1, -1, 1, 1, 1, 1,
                       0,
                       1, -1, -1, 1, 1, -1, 1, -1, 1, -1, -1, -1, -1, -1, 1, 1, -1, -1, 1, -1, 1, -1, 1, 1, 1, 1,
                       0, 0, 0, 0, 0};

  ofdm_ltf_inserter #(.AMPLITUDE(AMP), .NUM_LTF(NLTF)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .sof_i   (sof_i),
    .i_tdata (i_tdata),
    .i_tlast (i_tlast),
    .i_tvalid(i_tvalid),
    .i_tready(i_tready),
    .o_tdata (o_tdata),
    .o_tlast (o_tlast),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready),
    .o_sof   (o_sof)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Output ready: always 1, or a fair coin when rdy_rand is set.
  always @(posedge clk) begin
    #1;
    o_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: record transferred beats and check that stalled outputs hold.
  beat_t prev_beat;
  logic  prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_i && prev_stall)
      check("stall_hold", {o_tvalid, o_tdata, o_tlast, o_sof}, {1'b1, prev_beat});
    prev_stall = (o_tvalid === 1'b1) && (o_tready === 1'b0) && !rst_i;
    prev_beat  = '{o_tdata, o_tlast, o_sof};
    if (!rst_i && o_tvalid === 1'b1 && o_tready === 1'b1)
      cap_q.push_back('{o_tdata, o_tlast, o_sof});
  end

  task automatic push_preamble();
    logic signed [15:0] neg_amp;
    neg_amp = -AMP;
    for (int l = 0; l < NLTF; l++)
      for (int b = 0; b < 64; b++) begin
        logic [31:0] d;
        if (ltf_tab[b] == 0)      d = 32'd0;
        else if (ltf_tab[b] > 0)  d = {AMP, 16'h0000};
        else                      d = {neg_amp, 16'h0000};
        exp_q.push_back('{d, b == 63, (l == 0) && (b == 0)});
      end
  endtask

  task automatic push_data(input int first, input int n);
    for (int k = first; k < first + n; k++)
      exp_q.push_back('{din_q[k], (k % 64) == 63, 1'b0});
  endtask

  task automatic drive_stream(input int gap_pct);
    int   idx = 0;
    int   guard = 0;
    logic acc = 1'b0;
    n_acc = 0;
    while (idx < din_q.size() && guard < 20000) begin
      @(posedge clk); #1;
      if (acc) i_tvalid = 1'b0;
      if (!i_tvalid && $urandom_range(0, 99) >= gap_pct) begin
        i_tvalid = 1'b1;
        i_tdata  = din_q[idx];
        i_tlast  = (idx % 64) == 63;
      end
      @(negedge clk);
      acc = i_tvalid && i_tready;
      if (acc) begin
        idx++;
        n_acc = idx;
      end
      guard++;
    end
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    check("drive_done", idx, din_q.size());
  endtask

  task automatic wait_out(input int n);
    int g = 0;
    while (cap_q.size() < n && g < 20000) begin
      @(negedge clk);
      g++;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic compare_stream(input string name);
    check({name, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s[%0d]", name, i), cap_q[i], exp_q[i]);
  endtask

  task automatic clear_all();
    cap_q.delete();
    exp_q.delete();
    din_q.delete();
  endtask

  task automatic pulse_sof();
    @(posedge clk); #1 sof_i = 1'b1;
    @(posedge clk); #1 sof_i = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    tbl[0]  = '{0,   32'h0000_0000, 1'b0, 1'b1};
    tbl[1]  = '{5,   32'h0000_0000, 1'b0, 1'b0};
    tbl[2]  = '{6,   32'h4000_0000, 1'b0, 1'b0};
    tbl[3]  = '{7,   32'h4000_0000, 1'b0, 1'b0};
    tbl[4]  = '{8,   32'hC000_0000, 1'b0, 1'b0};
    tbl[5]  = '{32,  32'h0000_0000, 1'b0, 1'b0};
    tbl[6]  = '{34,  32'hC000_0000, 1'b0, 1'b0};
    tbl[7]  = '{63,  32'h0000_0000, 1'b1, 1'b0};
    tbl[8]  = '{64,  32'h0000_0000, 1'b0, 1'b0};
    tbl[9]  = '{70,  32'h4000_0000, 1'b0, 1'b0};
    tbl[10] = '{72,  32'hC000_0000, 1'b0, 1'b0};
    tbl[11] = '{127, 32'h0000_0000, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {o_tvalid, o_tlast, o_sof, o_tdata}, 35'd0);
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_tready", i_tready, 1'b1);

    // One-cycle latency with a one-sample packet
    @(posedge clk); #1;
    i_tvalid = 1'b1; i_tdata = 32'hDEAD_BEEF; i_tlast = 1'b1;
    @(negedge clk);
    check("lat_tready", i_tready, 1'b1);
    @(posedge clk); #1 i_tvalid = 1'b0;
    @(negedge clk);
    check("lat_beat", {o_tvalid, o_tdata, o_tlast, o_sof}, {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0});
    @(negedge clk);
    check("lat_idle", o_tvalid, 1'b0);
    clear_all();

    // Test 1: pass-through of three counting symbols
    for (int k = 0; k < 192; k++) din_q.push_back(32'(k));
    push_data(0, 192);
    drive_stream(0);
    wait_out(192);
    compare_stream("t1_pass");
    clear_all();

    // Test 2: preamble from idle, then one symbol
    for (int k = 0; k < 64; k++) din_q.push_back(32'h0100_0000 + 32'(k));
    push_preamble();
    push_data(0, 64);
    pulse_sof();
    drive_stream(0);
    wait_out(64 * NLTF + 64);
    compare_stream("t2_pre");
    for (int i = 0; i < 12; i++)
      if (tbl[i].beat < cap_q.size())
        check($sformatf("t2_tbl_beat%0d", tbl[i].beat), cap_q[tbl[i].beat],
              {tbl[i].data, tbl[i].last, tbl[i].sof});
      else
        check($sformatf("t2_tbl_missing%0d", tbl[i].beat), cap_q.size(), tbl[i].beat + 1);
    clear_all();

    // Test 3: sof edge while symbol 0 is in flight
    for (int k = 0; k < 192; k++) din_q.push_back(32'h2000_0000 + 32'(k));
    push_data(0, 64);
    push_preamble();
    push_data(64, 128);
    fork
      drive_stream(0);
      begin
        int g = 0;
        while (n_acc < 10 && g < 5000) begin
          @(negedge clk);
          g++;
        end
        @(posedge clk); #1 sof_i = 1'b1;
        @(posedge clk); #1 sof_i = 1'b0;
      end
    join
    wait_out(192 + 64 * NLTF);
    compare_stream("t3_mid");
    clear_all();

    // Test 4: random data, random gaps and random back-pressure
    rdy_rand = 1'b1;
    for (int k = 0; k < 256; k++) din_q.push_back($urandom);
    push_preamble();
    push_data(0, 256);
    pulse_sof();
    drive_stream(40);
    wait_out(256 + 64 * NLTF);
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    compare_stream("t4_rand");
    clear_all();

    // Test 5: long sof level gives one preamble per rising edge
    @(posedge clk); #1 sof_i = 1'b1;
    repeat (200) @(posedge clk);
    #1 sof_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 sof_i = 1'b1;
    repeat (10) @(posedge clk);
    #1 sof_i = 1'b0;
    push_preamble();
    push_preamble();
    wait_out(128 * NLTF);
    compare_stream("t5_level");
    clear_all();

    // Test 6: reset mid-preamble, then clean pass-through and full preamble
    pulse_sof();
    begin
      int g = 0;
      while (cap_q.size() < 30 && g < 5000) begin
        @(negedge clk);
        g++;
      end
    end
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    check("t6_rst_tvalid", o_tvalid, 1'b0);
    clear_all();
    for (int k = 0; k < 64; k++) din_q.push_back(32'h3000_0000 + 32'(k));
    push_data(0, 64);
    drive_stream(0);
    wait_out(64);
    compare_stream("t6_pass");
    cap_q.delete();
    exp_q.delete();
    push_preamble();
    pulse_sof();
    wait_out(64 * NLTF);
    compare_stream("t6_pre");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ofdm_ltf_inserter.md
Name: ofdm_ltf_inserter

Overview:
Transmit-side counterpart of the receive one-tap equalizer. On each new frame it emits the IEEE 802.11 long training field (64-bin frequency-domain LTF) as one or more 64-sample packets ahead of the frame's data symbols, so the receiver can estimate its equalization factor. Sits after the TX symbol mapper and before the IFFT. Between preambles it forwards data symbols unchanged. All streams carry 32-bit complex samples: I in [31:16], Q in [15:0], both signed.

Parameters:
AMPLITUDE, 16'sd16384, magnitude used for ±1 LTF bins. Legal range 1..32767.
NUM_LTF, 2, number of back-to-back LTF packets per frame. Legal range 1..3.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
sof_i  in  1  start-of-frame level; a rising edge (sof_i high, previous-cycle sof_i low) arms one preamble
i_tdata  in  32  data symbol samples, one 64-sample symbol per packet
i_tlast  in  1  last sample of symbol
i_tvalid  in  1  AXI-stream valid
i_tready  out  1  AXI-stream ready
o_tdata  out  32  preamble or data samples
o_tlast  out  1  last sample of each 64-sample packet
o_tvalid  out  1  AXI-stream valid
o_tready  in  1  AXI-stream ready
o_sof  out  1  high together with the first beat of the first LTF of a frame

Behaviour:
- Reset: o_tvalid=0, o_tlast=0, o_sof=0, o_tdata=0, state=PASS, pending=0, in_pkt=0, bin counter=0, LTF counter=0, last_sof=0.
- Output is a single register stage. load = ~o_tvalid | o_tready. Full throughput is 1 beat/cycle. Input-to-output latency is 1 cycle.
- A beat transfers on valid & ready. Outputs hold stable while o_tvalid & ~o_tready.
- sof edge: pending <= 1. In PASS with pending=0 it is ignored when already in PREAMBLE. The edge on the cycle pending clears is a new pending.
- in_pkt: set on an accepted input beat with i_tlast=0; cleared on an accepted beat with i_tlast=1.
- State PASS:
  - i_tready = load.
  - On an accepted beat, the register loads {i_tlast, i_tdata} and o_tvalid <= 1.
  - With load and no input, o_tvalid <= 0.
  - If pending & ~in_pkt at a load cycle, go to PREAMBLE instead of accepting input, and clear pending. An in-progress symbol always completes first.
- State PREAMBLE:
  - i_tready=0.
  - Each load cycle loads the LTF sample for bin b (0..63), with o_tvalid=1 and o_tlast=(b==63).
  - o_sof=(b==0 & LTF counter==0); otherwise o_sof=0.
  - b wraps 63->0 and increments the LTF counter. After bin 63 of LTF NUM_LTF-1 is loaded, go to PASS and zero both counters.
- LTF sample mapping: +1 -> I=AMPLITUDE, Q=0; -1 -> I=-AMPLITUDE (16-bit two's complement), Q=0; 0 -> 32'd0.
- LTF table, bins 0..63:
  - bins 0-5: 0
  - bins 6-31: 1 1 -1 -1 1 1 -1 1 -1 1 1 1 1 1 1 -1 -1 1 1 -1 1 -1 1 1 1 1
  - bin 32: 0
  - bins 33-58: 1 -1 -1 1 1 -1 1 -1 1 -1 -1 -1 -1 -1 1 1 -1 -1 1 -1 1 -1 1 1 1 1
  - bins 59-63: 0
- Data samples pass through bit-exact. No rounding or scaling.
- Input packets are assumed to be 64 samples. Other lengths are forwarded unmodified; tlast is passed through.
- rst_i mid-operation: all state is cleared on the next edge. A partial preamble is abandoned, and pending is lost.
- sof_i held high for many cycles produces exactly one preamble.

Test Plan:
1. No sof edge; 3 input symbols of 64 beats, counting pattern, o_tready=1 -> output identical to input, delayed 1 cycle; tlast on beats 63/127/191; o_sof never high.
2. sof pulse while idle, AMPLITUDE=16384, NUM_LTF=2, then 1 symbol input -> 128 preamble beats first:
   - beats 0-5 = 0x00000000
   - beat 6 = 0x40000000
   - beat 8 = 0xC0000000
   - beat 32 = 0x00000000
   - beats 70 and 72 match beats 6 and 8
   - tlast on beats 63 and 127; o_sof only on beat 0
   - then the 64 data beats unchanged.
3. sof edge while input beat 10 of a symbol is in flight -> beats 10-63 of that symbol emitted first, then the preamble, then the remaining symbols; no sample lost or duplicated.
4. Random o_tready (50%) and random i_tvalid gaps over a 4-symbol frame with preamble -> output sequence equals the reference model exactly; o_tdata/o_tlast stable whenever o_tvalid & ~o_tready.
5. sof_i held high 200 cycles, then low, then high again -> exactly two preambles, one per rising edge.
6. rst_i asserted for 1 cycle at preamble beat 30 -> o_tvalid=0 the cycle after; the next output is pass-through input with no preamble remnant; a subsequent sof edge yields a full 64·NUM_LTF preamble.
